// File: rtl/line_memory_pkg.sv
// Shared defaults for the line memory and the cache miss path.
// Word/line widths, depth and latency live here so both sides agree.
package line_memory_pkg;

  localparam int unsigned WORD_BITS           = 32;
  localparam int unsigned LINE_WORDS          = 4;
  localparam int unsigned LINE_BITS           = WORD_BITS * LINE_WORDS;
  localparam int unsigned MEM_ADDR_WIDTH      = 20;
  localparam int unsigned MEMORY_SIZE         = 1024;
  localparam int unsigned MEMORY_DELAY_CYCLES = 5;

  // Latency counter must hold the value DELAY_CYCLES itself.
  function automatic int unsigned count_width(input int unsigned delay);
    return $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/line_memory_ctrl.sv
// Request handshake for the line memory: IDLE/BUSY FSM, latency counter,
// latched request, ready and the one-cycle response pulse.
module line_memory_ctrl
  import line_memory_pkg::*;
#(
  parameter int unsigned IDX_WIDTH    = 10,
  parameter int unsigned LINE_WIDTH   = LINE_BITS,
  parameter int unsigned DELAY_CYCLES = MEMORY_DELAY_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  requested,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  idx_in,
  input  logic [LINE_WIDTH-1:0] wr_data,
  input  logic                  reset_mem_req,
  input  logic                  is_loading,
  output logic                  ready_c,
  output logic                  complete_c,
  output logic                  resp_valid,
  output logic                  req_we,
  output logic [IDX_WIDTH-1:0]  req_idx,
  output logic [LINE_WIDTH-1:0] req_data
);

  localparam int unsigned CNT_W = count_width(DELAY_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  assign ready_c = (state == IDLE) && !is_loading;

  // Completion edge; an abort or reset on the same edge suppresses it.
  assign complete_c = (state == BUSY) && (count == CNT_W'(1)) &&
                      !reset_mem_req && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      resp_valid <= 1'b0;
      req_we     <= 1'b0;
      req_idx    <= '0;
      req_data   <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (requested && ready_c && !reset_mem_req) begin
            state    <= BUSY;
            count    <= CNT_W'(DELAY_CYCLES);
            req_we   <= we;
            req_idx  <= idx_in;
            req_data <= wr_data;
          end
        end
        BUSY: begin
          if (reset_mem_req) begin
            state <= IDLE;
            count <= '0;
          end else if (count == CNT_W'(1)) begin
            state      <= IDLE;
            count      <= '0;
            resp_valid <= 1'b1;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/line_memory.sv
// Fixed-latency line-granular main memory with a word-wide loader port.
// Storage is banked by low index bits so each word of a line hits its own bank.
module line_memory
  import line_memory_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = WORD_BITS,
  parameter int unsigned WORDS_PER_LINE = LINE_WORDS,
  parameter int unsigned ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int unsigned DEPTH_WORDS    = MEMORY_SIZE,
  parameter int unsigned DELAY_CYCLES   = MEMORY_DELAY_CYCLES
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 requested,
  input  logic                                 we,
  input  logic [ADDR_WIDTH-1:0]                addr_in,
  input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] wr_data,
  input  logic                                 reset_mem_req,
  output logic                                 ready,
  output logic                                 resp_valid,
  output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] rd_data_out,
  input  logic                                 is_loading_memory_into_core,
  input  logic [ADDR_WIDTH-1:0]                addr_to_core_mem,
  input  logic [WORD_WIDTH-1:0]                data_to_core_mem
);

  localparam int unsigned LINE_WIDTH = WORD_WIDTH * WORDS_PER_LINE;
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam int unsigned OFF_W      = $clog2(WORDS_PER_LINE);
  localparam int unsigned ROWS       = DEPTH_WORDS / WORDS_PER_LINE;
  localparam int unsigned ROW_W      = $clog2(ROWS);

  logic                  ready_c;
  logic                  complete_c;
  logic                  req_we;
  logic [IDX_W-1:0]      req_idx;
  logic [LINE_WIDTH-1:0] req_data;
  logic [IDX_W-1:0]      load_idx;
  int unsigned           start_off;
  logic [LINE_WIDTH-1:0] bank_rd;
  logic [LINE_WIDTH-1:0] rd_line;

  // Address bits above the storage index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_in[ADDR_WIDTH-1:IDX_W],
                              addr_to_core_mem[ADDR_WIDTH-1:IDX_W]};

  line_memory_ctrl #(
    .IDX_WIDTH   (IDX_W),
    .LINE_WIDTH  (LINE_WIDTH),
    .DELAY_CYCLES(DELAY_CYCLES)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .requested    (requested),
    .we           (we),
    .idx_in       (addr_in[IDX_W-1:0]),
    .wr_data      (wr_data),
    .reset_mem_req(reset_mem_req),
    .is_loading   (is_loading_memory_into_core),
    .ready_c      (ready_c),
    .complete_c   (complete_c),
    .resp_valid   (resp_valid),
    .req_we       (req_we),
    .req_idx      (req_idx),
    .req_data     (req_data)
  );

  assign ready     = ready_c;
  assign load_idx  = addr_to_core_mem[IDX_W-1:0];
  assign start_off = 32'(req_idx) % WORDS_PER_LINE;

  for (genvar b = 0; b < WORDS_PER_LINE; b++) begin : g_bank
    localparam int unsigned BANK = b;

    logic [WORD_WIDTH-1:0] bank_mem [ROWS];
    int unsigned           line_word;
    logic [IDX_W-1:0]      word_idx;
    logic [ROW_W-1:0]      line_row;
    logic [ROW_W-1:0]      load_row;
    logic                  load_hit;

    // Which word of the current line falls in this bank, and at which row.
    always_comb begin
      line_word = (BANK + WORDS_PER_LINE - start_off) % WORDS_PER_LINE;
      word_idx  = req_idx + IDX_W'(line_word);
      line_row  = ROW_W'(word_idx >> OFF_W);
      load_row  = ROW_W'(load_idx >> OFF_W);
      load_hit  = (32'(load_idx) % WORDS_PER_LINE) == BANK;
    end

    // Loader write comes last so it wins a same-index collision.
    always_ff @(posedge clk) begin
      if (complete_c && req_we) begin
        bank_mem[line_row] <= req_data[line_word*WORD_WIDTH +: WORD_WIDTH];
      end
      if (is_loading_memory_into_core && load_hit) begin
        bank_mem[load_row] <= data_to_core_mem;
      end
    end

    assign bank_rd[BANK*WORD_WIDTH +: WORD_WIDTH] = bank_mem[line_row];
  end

  // Rotate bank outputs back into line order.
  always_comb begin
    rd_line = '0;
    for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
      rd_line[k*WORD_WIDTH +: WORD_WIDTH] =
        bank_rd[((start_off + k) % WORDS_PER_LINE)*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_out <= '0;
    end else if (complete_c && !req_we) begin
      rd_data_out <= rd_line;
    end
  end

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: handshake timing, wrap, abort, loader
// collisions and reset, all against hand-computed lines.
module tb_line_memory;
  import line_memory_pkg::*;

  localparam int unsigned W   = WORD_BITS;
  localparam int unsigned N   = LINE_WORDS;
  localparam int unsigned LW  = LINE_BITS;
  localparam int unsigned AW  = MEM_ADDR_WIDTH;
  localparam int unsigned DLY = MEMORY_DELAY_CYCLES;

  logic          clk;
  logic          reset;
  logic          requested;
  logic          we;
  logic [AW-1:0] addr_in;
  logic [LW-1:0] wr_data;
  logic          reset_mem_req;
  logic          ready;
  logic          resp_valid;
  logic [LW-1:0] rd_data_out;
  logic          is_loading_memory_into_core;
  logic [AW-1:0] addr_to_core_mem;
  logic [W-1:0]  data_to_core_mem;

  int checks = 0;
  int errors = 0;

  logic [LW-1:0] l1, l2, l3, l3_off, l5, l5_55, l5_66;

  line_memory #(
    .WORD_WIDTH    (W),
    .WORDS_PER_LINE(N),
    .ADDR_WIDTH    (AW),
    .DEPTH_WORDS   (MEMORY_SIZE),
    .DELAY_CYCLES  (DLY)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .requested                  (requested),
    .we                         (we),
    .addr_in                    (addr_in),
    .wr_data                    (wr_data),
    .reset_mem_req              (reset_mem_req),
    .ready                      (ready),
    .resp_valid                 (resp_valid),
    .rd_data_out                (rd_data_out),
    .is_loading_memory_into_core(is_loading_memory_into_core),
    .addr_to_core_mem           (addr_to_core_mem),
    .data_to_core_mem           (data_to_core_mem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [W-1:0] d);
    is_loading_memory_into_core = 1'b1;
    addr_to_core_mem = a;
    data_to_core_mem = d;
    @(negedge clk);
    is_loading_memory_into_core = 1'b0;
  endtask

  // Returns at the negedge just after the accepting edge.
  task automatic start_req(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", LW'(ready), LW'(1));
    requested = 1'b1;
    we        = w;
    addr_in   = a;
    wr_data   = d;
    @(negedge clk);
    requested = 1'b0;
    check("ready_low_after_accept", LW'(ready), LW'(0));
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, LW'(n), LW'(DLY));
    check({tag, "_ready_in_resp"}, LW'(ready), LW'(1));
    @(negedge clk);
    check({tag, "_single_pulse"}, LW'(resp_valid), LW'(0));
  endtask

  task automatic read_line(input logic [AW-1:0] a, input logic [LW-1:0] exp, input string tag);
    start_req(1'b0, a, '0);
    wait_resp(tag);
    check({tag, "_data"}, rd_data_out, exp);
  endtask

  initial begin
    l1     = 128'h00000044_00000033_00000022_00000011;
    l2     = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    l3     = 128'h0BAD0003_0BAD0002_0BAD0001_0BAD0000;
    l3_off = 128'hABCD0002_0BAD0003_0BAD0002_0BAD0001;
    l5     = 128'h44440003_44440002_44440001_44440000;
    l5_55  = 128'h44440003_44440002_00000055_44440000;
    l5_66  = 128'h44440003_44440002_00000066_44440000;

    reset = 1'b1;
    requested = 1'b0;
    we = 1'b0;
    addr_in = '0;
    wr_data = '0;
    reset_mem_req = 1'b0;
    is_loading_memory_into_core = 1'b0;
    addr_to_core_mem = '0;
    data_to_core_mem = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", LW'(ready), LW'(1));
    check("rst_resp_valid", LW'(resp_valid), LW'(0));
    check("rst_rd_data", rd_data_out, '0);
    reset = 1'b0;
    @(negedge clk);

    // Loader preload; ready must drop while loading.
    is_loading_memory_into_core = 1'b1;
    #1 check("ready_low_while_loading", LW'(ready), LW'(0));
    for (int i = 0; i < 4; i++) load_word(AW'(32'h10 + i), W'(32'h11 * (i + 1)));
    read_line(20'h10, l1, "rd10");

    // Write with input change after accept; rd_data_out untouched by writes.
    start_req(1'b1, 20'h20, l2);
    wr_data = ~l2;
    addr_in = 20'h30;
    wait_resp("wr20");
    check("rd_hold_after_write", rd_data_out, l1);
    read_line(20'h20, l2, "rd20");

    // Wrap at the top of storage and ignored upper address bit.
    load_word(20'h002, 32'hABCD0002);
    start_req(1'b1, 20'h3FE, l3);
    wait_resp("wr3fe");
    read_line(20'h7FE, l3, "rd7fe");
    read_line(20'h3FF, l3_off, "rd3ff");

    // Abort two cycles after accept, then an immediate new read.
    start_req(1'b0, 20'h10, '0);
    @(negedge clk);
    reset_mem_req = 1'b1;
    @(negedge clk);
    reset_mem_req = 1'b0;
    check("abort_ready", LW'(ready), LW'(1));
    check("abort_resp_valid", LW'(resp_valid), LW'(0));
    check("abort_rd_hold", rd_data_out, l3_off);
    read_line(20'h20, l2, "rd_after_abort");

    // Abort on the completion edge wins.
    start_req(1'b0, 20'h10, '0);
    repeat (4) @(negedge clk);
    reset_mem_req = 1'b1;
    @(negedge clk);
    reset_mem_req = 1'b0;
    check("late_abort_resp_valid", LW'(resp_valid), LW'(0));
    check("late_abort_rd_hold", rd_data_out, l2);
    check("late_abort_ready", LW'(ready), LW'(1));

    // Abort in IDLE blocks acceptance.
    requested = 1'b1;
    addr_in = 20'h10;
    we = 1'b0;
    reset_mem_req = 1'b1;
    @(negedge clk);
    requested = 1'b0;
    reset_mem_req = 1'b0;
    check("idle_abort_blocks_accept", LW'(ready), LW'(1));

    // Loader collides with completion write: loader word wins.
    start_req(1'b1, 20'h40, l5);
    repeat (4) @(negedge clk);
    is_loading_memory_into_core = 1'b1;
    addr_to_core_mem = 20'h41;
    data_to_core_mem = 32'h55;
    @(negedge clk);
    is_loading_memory_into_core = 1'b0;
    check("wr40_resp", LW'(resp_valid), LW'(1));
    @(negedge clk);
    read_line(20'h40, l5_55, "rd40_loader_win");

    // Read on the same edge as a loader write returns the pre-edge value.
    start_req(1'b0, 20'h40, '0);
    repeat (4) @(negedge clk);
    is_loading_memory_into_core = 1'b1;
    addr_to_core_mem = 20'h41;
    data_to_core_mem = 32'h66;
    @(negedge clk);
    is_loading_memory_into_core = 1'b0;
    check("rd40_pre_edge_resp", LW'(resp_valid), LW'(1));
    check("rd40_pre_edge_data", rd_data_out, l5_55);
    @(negedge clk);
    read_line(20'h40, l5_66, "rd40_after_load");

    // Reset mid-BUSY clears control state but not storage.
    start_req(1'b0, 20'h20, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", LW'(ready), LW'(1));
    check("midrst_resp_valid", LW'(resp_valid), LW'(0));
    check("midrst_rd_data", rd_data_out, '0);
    read_line(20'h20, l2, "rd20_after_rst");
    read_line(20'h40, l5_66, "rd40_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_memory.md
Name: line_memory

Overview:
- Parametrised, fixed-latency line-granular main-memory model for the Elpis core. Successor to the flat 4-word memory.
- Sits behind the cache miss path and serves line reads and writes through a request/ready handshake with a DELAY_CYCLES latency.
- A separate loader port preloads program images word by word before the core runs.
- New over the previous generation: latched request, abortable transactions, registered read data with a response pulse, configurable line size, depth and latency.

Parameters:
- WORD_WIDTH, 32, bits per stored word.
- WORDS_PER_LINE, 4, words per line transfer; power of two ≥1.
- ADDR_WIDTH, 20, word-address width on both ports.
- DEPTH_WORDS, 1024, storage words; power of two; index = addr[log2(DEPTH_WORDS)-1:0].
- DELAY_CYCLES, 5, access latency in cycles; ≥1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- requested  in  1  transaction request.
- we  in  1  1 = write line, 0 = read line; sampled with requested.
- addr_in  in  ADDR_WIDTH  word address of word 0 of the line.
- wr_data  in  WORD_WIDTH*WORDS_PER_LINE  line data; word k in bits [k*WORD_WIDTH +: WORD_WIDTH].
- reset_mem_req  in  1  abort of the in-flight transaction.
- ready  out  1  memory idle and able to accept a request.
- resp_valid  out  1  one-cycle completion pulse.
- rd_data_out  out  WORD_WIDTH*WORDS_PER_LINE  registered read line.
- is_loading_memory_into_core  in  1  loader write enable.
- addr_to_core_mem  in  ADDR_WIDTH  loader word address.
- data_to_core_mem  in  WORD_WIDTH  loader word data.

Behaviour:
- States: IDLE and BUSY. Counter width is clog2(DELAY_CYCLES+1).
- Reset values: state IDLE, count 0, ready 1, resp_valid 0, rd_data_out 0.
- Storage is not cleared by reset and is undefined until written.
- ready = (state==IDLE) && !is_loading_memory_into_core.
- Accept: at an edge where requested && ready, latch we/addr_in/wr_data, count = DELAY_CYCLES, go to BUSY. Inputs may change after acceptance.
- BUSY: decrement count each edge.
- Completion: at the edge where count==1 (DELAY_CYCLES edges after acceptance):
  - A write stores word k at index (addr+k) mod DEPTH_WORDS.
  - A read loads rd_data_out the same way.
  - Go to IDLE. resp_valid=1 for exactly the following cycle, and ready is also 1 in that cycle.
- Back-to-back: a request accepted in the resp_valid cycle is legal, giving one request every DELAY_CYCLES+1 cycles.
- rd_data_out holds its value until the next read completion. Write completions and aborts leave it unchanged.
- Address wrap: a line crossing the top of storage wraps to index 0. Address bits above log2(DEPTH_WORDS) are ignored.
- Abort: reset_mem_req in BUSY returns to IDLE on that edge, with no storage write, no rd_data_out update and no resp_valid. If reset_mem_req coincides with the completion edge, the abort wins. reset_mem_req in IDLE blocks acceptance on that edge.
- Loader: whenever is_loading_memory_into_core=1, write data_to_core_mem at index addr_to_core_mem every edge, in any state.
- Loader during BUSY: the transaction continues. If the loader write and the completion write hit the same index on the same edge, the loader word wins; other words of the line are still written.
- Priority: reset > reset_mem_req > completion/accept; the loader is independent of this chain.
- A read completing on the same edge as a loader write to an overlapping index returns the pre-edge value.

Decomposition:
- Shared definitions package holds the default values MEMORY_SIZE, MEMORY_DELAY_CYCLES and line/word widths, reused by the cache.
- State encoding stays local to the module.
- One natural sub-module: line_memory_ctrl, containing the FSM, counter, request latches, ready and resp_valid.
- The storage array and the word-index generation remain in the top module.

Test Plan:
- Loader writes 0x11,0x22,0x33,0x44 at 0x10..0x13, then read addr 0x10 → ready falls the next cycle; resp_valid on cycle 6; rd_data_out=0x00000044_00000033_00000022_00000011.
- Write line 0xDEADBEEF_CAFEF00D_12345678_9ABCDEF0 to 0x20; change wr_data after accept; read 0x20 → originally latched line returned, one resp_valid per transaction, rd_data_out unchanged after the write.
- Write to 0x3FE (DEPTH 1024) → words land at indices 0x3FE, 0x3FF, 0x000, 0x001; read 0x7FE returns the same line (upper bit ignored).
- Read 0x10, assert reset_mem_req 2 cycles after accept → no resp_valid; ready=1 the next cycle; rd_data_out keeps its previous value; a new read accepts immediately.
- Write to 0x40 with a loader write of 0x55 to 0x41 on the completion edge → read returns word1=0x55 and words 0, 2, 3 from the line.
- Assert reset mid-BUSY → the next cycle shows ready=1, resp_valid=0, rd_data_out=0, and storage keeps its contents.
